// File: rtl/cfg_arb_pkg.sv
// Shared state type, timeout error data and index-width helper for cfg_reg_arbiter.
package cfg_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2
    } arb_state_t;

    localparam int MAX_DATA_WIDTH = 1024;
    localparam logic [MAX_DATA_WIDTH-1:0] TIMEOUT_ERR_DATA = '0;

    function automatic int idx_width(input int ports);
        return (ports > 1) ? $clog2(ports) : 1;
    endfunction

endpackage

// File: rtl/cfg_rr_select.sv
// Combinational round-robin pick: search starts one past last_grant and wraps.
module cfg_rr_select #(
    parameter int PORTS = 2,
    parameter int IDX_W = 1
) (
    input  logic [PORTS-1:0] req,
    input  logic [IDX_W-1:0] last_grant,
    output logic [PORTS-1:0] grant,
    output logic [IDX_W-1:0] grant_idx
);

    logic [IDX_W-1:0]   start;
    logic [2*PORTS-1:0] dbl;
    logic [IDX_W:0]     sum;
    logic               found;

    // Rotate the request vector so the search origin sits at bit 0; the
    // descending loop leaves the lowest set offset, i.e. the first in turn.
    always_comb begin
        start     = (last_grant >= IDX_W'(PORTS - 1)) ? '0 : last_grant + IDX_W'(1);
        dbl       = {req, req} >> start;
        sum       = '0;
        found     = 1'b0;
        grant     = '0;
        grant_idx = '0;
        for (int i = PORTS - 1; i >= 0; i--) begin
            if (dbl[i]) begin
                sum   = {1'b0, start} + (IDX_W + 1)'(i);
                found = 1'b1;
            end
        end
        if (found) begin
            if (sum >= (IDX_W + 1)'(PORTS)) begin
                sum = sum - (IDX_W + 1)'(PORTS);
            end
            grant_idx = sum[IDX_W-1:0];
            grant     = PORTS'(1) << grant_idx;
        end
    end

endmodule

// File: rtl/cfg_reg_arbiter.sv
// Round-robin arbiter sharing one register port, one transaction in flight.
// Define CFG_ARB_TIMEOUT_EN to enable the read timeout (error response after TIMEOUT cycles).
module cfg_reg_arbiter
    import cfg_arb_pkg::*;
#(
    parameter int PORTS      = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int TIMEOUT    = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [PORTS-1:0]              s_req_valid,
    output logic [PORTS-1:0]              s_req_ready,
    input  logic [PORTS-1:0]              s_req_we,
    input  logic [PORTS*ADDR_WIDTH-1:0]   s_req_addr,
    input  logic [PORTS*DATA_WIDTH-1:0]   s_req_wdata,
    input  logic [PORTS*STRB_WIDTH-1:0]   s_req_wstrb,
    output logic [PORTS-1:0]              s_rsp_valid,
    output logic [DATA_WIDTH-1:0]         s_rsp_data,
    output logic                          s_rsp_err,
    output logic                          m_rd,
    output logic [ADDR_WIDTH-1:0]         m_raddr,
    input  logic [DATA_WIDTH-1:0]         m_rdata,
    input  logic                          m_rvalid,
    output logic                          m_wr,
    output logic [ADDR_WIDTH-1:0]         m_waddr,
    output logic [DATA_WIDTH-1:0]         m_wdata,
    output logic [STRB_WIDTH-1:0]         m_wstrb
);

    localparam int IDX_W = idx_width(PORTS);

    arb_state_t            state, state_n;
    logic [IDX_W-1:0]      last_grant, owner_idx;
    logic                  owner_we;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_WIDTH-1:0] wstrb_q;

    logic [PORTS-1:0]      grant;
    logic [IDX_W-1:0]      grant_idx;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [STRB_WIDTH-1:0] sel_wstrb;

    logic accept, rsp_done, rsp_from_bus, rsp_timeout, timed_out;

    cfg_rr_select #(
        .PORTS (PORTS),
        .IDX_W (IDX_W)
    ) u_rr_select (
        .req        (s_req_valid),
        .last_grant (last_grant),
        .grant      (grant),
        .grant_idx  (grant_idx)
    );

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_wstrb = '0;
        for (int i = 0; i < PORTS; i++) begin
            if (grant[i]) begin
                sel_we    = s_req_we[i];
                sel_addr  = s_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = s_req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                sel_wstrb = s_req_wstrb[i*STRB_WIDTH +: STRB_WIDTH];
            end
        end
    end

`ifdef CFG_ARB_TIMEOUT_EN
    localparam int TCNT_W = $clog2(TIMEOUT + 1);
    logic [TCNT_W-1:0] tcnt;

    // Counts read cycles without data since the m_rd cycle; saturates at TIMEOUT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tcnt <= '0;
        end else if (accept) begin
            tcnt <= '0;
        end else if (((state == ISSUE && !owner_we) || state == WAIT_RD) && !m_rvalid
                     && tcnt != TCNT_W'(TIMEOUT)) begin
            tcnt <= tcnt + TCNT_W'(1);
        end
    end

    assign timed_out = (tcnt == TCNT_W'(TIMEOUT));
`else
    assign timed_out = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= IDX_W'(PORTS - 1);
            owner_idx  <= '0;
            owner_we   <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                last_grant <= grant_idx;
                owner_idx  <= grant_idx;
                owner_we   <= sel_we;
                addr_q     <= sel_addr;
                wdata_q    <= sel_wdata;
                wstrb_q    <= sel_wstrb;
            end
        end
    end

    // Data arriving in the same cycle as the timeout wins over the error.
    always_comb begin
        state_n      = state;
        accept       = 1'b0;
        rsp_done     = 1'b0;
        rsp_from_bus = 1'b0;
        rsp_timeout  = 1'b0;
        m_rd         = 1'b0;
        m_wr         = 1'b0;
        case (state)
            IDLE: begin
                if (|grant) begin
                    accept  = 1'b1;
                    state_n = ISSUE;
                end
            end
            ISSUE: begin
                if (owner_we) begin
                    m_wr     = 1'b1;
                    rsp_done = 1'b1;
                    state_n  = IDLE;
                end else begin
                    m_rd = 1'b1;
                    if (m_rvalid) begin
                        rsp_done     = 1'b1;
                        rsp_from_bus = 1'b1;
                        state_n      = IDLE;
                    end else begin
                        state_n = WAIT_RD;
                    end
                end
            end
            WAIT_RD: begin
                if (m_rvalid) begin
                    rsp_done     = 1'b1;
                    rsp_from_bus = 1'b1;
                    state_n      = IDLE;
                end else if (timed_out) begin
                    rsp_done    = 1'b1;
                    rsp_timeout = 1'b1;
                    state_n     = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Ready is masked during reset so every output reads zero while rst is high.
    assign s_req_ready = (state == IDLE && !rst) ? grant : '0;
    assign s_rsp_valid = rsp_done ? (PORTS'(1) << owner_idx) : '0;
    assign s_rsp_err   = rsp_timeout;
    assign s_rsp_data  = rsp_from_bus ? m_rdata :
                         rsp_timeout  ? TIMEOUT_ERR_DATA[DATA_WIDTH-1:0] : '0;

    assign m_raddr = (state != IDLE && !owner_we) ? addr_q : '0;
    assign m_waddr = m_wr ? addr_q  : '0;
    assign m_wdata = m_wr ? wdata_q : '0;
    assign m_wstrb = m_wr ? wstrb_q : '0;

endmodule

// File: tb/tb_cfg_reg_arbiter.sv
// Self-checking bench for cfg_reg_arbiter: vector table plus scoreboard of expected responses.
module tb_cfg_reg_arbiter;

    localparam int P  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [P-1:0]    s_req_valid = '0;
    logic [P-1:0]    s_req_ready;
    logic [P-1:0]    s_req_we = '0;
    logic [P*AW-1:0] s_req_addr = '0;
    logic [P*DW-1:0] s_req_wdata = '0;
    logic [P*SW-1:0] s_req_wstrb = '0;
    logic [P-1:0]    s_rsp_valid;
    logic [DW-1:0]   s_rsp_data;
    logic            s_rsp_err;
    logic            m_rd;
    logic [AW-1:0]   m_raddr;
    logic [DW-1:0]   m_rdata = '0;
    logic            m_rvalid = 1'b0;
    logic            m_wr;
    logic [AW-1:0]   m_waddr;
    logic [DW-1:0]   m_wdata;
    logic [SW-1:0]   m_wstrb;

    cfg_reg_arbiter #(
        .PORTS      (P),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .STRB_WIDTH (SW),
        .TIMEOUT    (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .s_req_valid (s_req_valid),
        .s_req_ready (s_req_ready),
        .s_req_we    (s_req_we),
        .s_req_addr  (s_req_addr),
        .s_req_wdata (s_req_wdata),
        .s_req_wstrb (s_req_wstrb),
        .s_rsp_valid (s_rsp_valid),
        .s_rsp_data  (s_rsp_data),
        .s_rsp_err   (s_rsp_err),
        .m_rd        (m_rd),
        .m_raddr     (m_raddr),
        .m_rdata     (m_rdata),
        .m_rvalid    (m_rvalid),
        .m_wr        (m_wr),
        .m_waddr     (m_waddr),
        .m_wdata     (m_wdata),
        .m_wstrb     (m_wstrb)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        int          port;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          rdelay;
        logic [31:0] rdata;
    } vec_t;

    typedef struct {
        int          port;
        logic [31:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    vec_t vecs[6];
    int   checks   = 0;
    int   failures = 0;
    int   cyc_cnt  = 0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc_cnt);
        end
    endtask

    // Every response is matched against the oldest expectation, including its cycle.
    always @(negedge clk) begin
        if (!rst) begin
            checkOutput("rd_wr_exclusive", {63'b0, m_rd & m_wr}, 64'd0);
            if (s_rsp_valid == '0) begin
                checkOutput("rsp_data_when_idle", {32'b0, s_rsp_data}, 64'd0);
            end else if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_rsp: got valid=%b data=0x%0h at cycle %0d, expected no response",
                         s_rsp_valid, s_rsp_data, cyc_cnt);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput("rsp_valid", {62'b0, s_rsp_valid}, 64'(1) << mon_e.port);
                checkOutput("rsp_data", {32'b0, s_rsp_data}, {32'b0, mon_e.data});
                checkOutput("rsp_err", {63'b0, s_rsp_err}, {63'b0, mon_e.err});
                checkOutput("rsp_cycle", 64'(cyc_cnt), 64'(mon_e.cyc));
            end
        end
    end

    task automatic pushExpect(input int port, input logic [31:0] data, input logic err, input int cyc);
        exp_t e;
        e.port = port;
        e.data = data;
        e.err  = err;
        e.cyc  = cyc;
        exp_q.push_back(e);
    endtask

    task automatic waitReady(input int p);
        int n = 0;
        @(negedge clk);
        while (!s_req_ready[p] && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("accept_ready", {62'b0, s_req_ready}, 64'(1) << p);
    endtask

    task automatic applyStimulus(input vec_t v);
        int p = v.port;
        s_req_we[p]              = v.we;
        s_req_addr[p*AW +: AW]   = v.addr;
        s_req_wdata[p*DW +: DW]  = v.wdata;
        s_req_wstrb[p*SW +: SW]  = v.wstrb;
        s_req_valid[p]           = 1'b1;
        waitReady(p);
        @(posedge clk);
        #1;
        s_req_valid[p] = 1'b0;
        if (v.we) begin
            if (v.rdelay == 0) begin
                m_rvalid = 1'b1;
                m_rdata  = v.rdata;
            end
            pushExpect(p, 32'h0, 1'b0, cyc_cnt);
            @(negedge clk);
            checkOutput("m_wr", {63'b0, m_wr}, 64'd1);
            checkOutput("m_rd_on_write", {63'b0, m_rd}, 64'd0);
            checkOutput("m_waddr", {32'b0, m_waddr}, {32'b0, v.addr});
            checkOutput("m_wdata", {32'b0, m_wdata}, {32'b0, v.wdata});
            checkOutput("m_wstrb", {60'b0, m_wstrb}, {60'b0, v.wstrb});
        end else begin
            if (v.rdelay == 0) begin
                m_rvalid = 1'b1;
                m_rdata  = v.rdata;
            end
            pushExpect(p, v.rdata, 1'b0, cyc_cnt + v.rdelay);
            @(negedge clk);
            checkOutput("m_rd", {63'b0, m_rd}, 64'd1);
            checkOutput("m_wr_on_read", {63'b0, m_wr}, 64'd0);
            checkOutput("m_raddr", {32'b0, m_raddr}, {32'b0, v.addr});
            for (int j = 1; j <= v.rdelay; j++) begin
                @(posedge clk);
                #1;
                if (j == v.rdelay) begin
                    m_rvalid = 1'b1;
                    m_rdata  = v.rdata;
                end
            end
        end
        @(posedge clk);
        #1;
        m_rvalid = 1'b0;
        m_rdata  = '0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int acc;
        int last_cyc;
        int exp_port;
        int budget;

        vecs[0] = '{we: 1'b1, port: 0, addr: 32'h10, wdata: 32'hA5A5A5A5, wstrb: 4'hF, rdelay: 1, rdata: 32'h0};
        vecs[1] = '{we: 1'b0, port: 1, addr: 32'h20, wdata: 32'h0, wstrb: 4'h0, rdelay: 3, rdata: 32'h12345678};
        vecs[2] = '{we: 1'b0, port: 1, addr: 32'h20, wdata: 32'h0, wstrb: 4'h0, rdelay: 0, rdata: 32'h12345678};
        vecs[3] = '{we: 1'b1, port: 1, addr: 32'h44, wdata: 32'hDEADBEEF, wstrb: 4'h3, rdelay: 0, rdata: 32'hBAD0BAD0};
        vecs[4] = '{we: 1'b0, port: 0, addr: 32'h8, wdata: 32'h0, wstrb: 4'h0, rdelay: 1, rdata: 32'hCAFEF00D};
        vecs[5] = '{we: 1'b1, port: 0, addr: 32'hFFFFFFFC, wdata: 32'h0, wstrb: 4'h0, rdelay: 1, rdata: 32'h0};

        // Both ports requesting writes while reset is held.
        s_req_valid = 2'b11;
        s_req_we    = 2'b11;
        s_req_addr  = {32'h104, 32'h100};
        s_req_wdata = {32'h11111111, 32'h00000000};
        s_req_wstrb = {4'hF, 4'hF};
        #12;
        checkOutput("reset_ready", {62'b0, s_req_ready}, 64'd0);
        checkOutput("reset_rsp_valid", {62'b0, s_rsp_valid}, 64'd0);
        checkOutput("reset_m_rd_wr", {62'b0, m_rd, m_wr}, 64'd0);
        checkOutput("reset_m_bus", {m_waddr, m_wdata} | {32'b0, m_raddr} | {60'b0, m_wstrb}, 64'd0);
        checkOutput("reset_rsp_data_err", {31'b0, s_rsp_err, s_rsp_data}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        acc      = 0;
        last_cyc = 0;
        exp_port = 0;
        budget   = 0;
        while (acc < 4 && budget < 40) begin
            @(negedge clk);
            budget++;
            if (s_req_ready != '0) begin
                checkOutput("rr_grant", {62'b0, s_req_ready}, 64'(1) << exp_port);
                if (acc > 0) checkOutput("rr_spacing", 64'(cyc_cnt - last_cyc), 64'd2);
                pushExpect(exp_port, 32'h0, 1'b0, cyc_cnt + 1);
                last_cyc = cyc_cnt;
                exp_port = 1 - exp_port;
                acc++;
            end
        end
        checkOutput("rr_accept_count", 64'(acc), 64'd4);
        @(posedge clk);
        #1;
        s_req_valid = '0;
        repeat (3) @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i]);
        end

`ifdef CFG_ARB_TIMEOUT_EN
        s_req_we[0]            = 1'b0;
        s_req_addr[0 +: AW]    = 32'h50;
        s_req_valid[0]         = 1'b1;
        waitReady(0);
        @(posedge clk);
        #1;
        s_req_valid[0] = 1'b0;
        pushExpect(0, 32'h0, 1'b1, cyc_cnt + 4);
        repeat (5) @(posedge clk);
        #1;
        m_rvalid = 1'b1;
        m_rdata  = 32'h77777777;
        @(posedge clk);
        #1;
        m_rvalid = 1'b0;
        m_rdata  = '0;
        repeat (2) @(posedge clk);
        #1;
`endif

        // Abort a read in WAIT_RD with an asynchronous reset.
        s_req_we[1]          = 1'b0;
        s_req_addr[AW +: AW] = 32'h30;
        s_req_valid[1]       = 1'b1;
        waitReady(1);
        @(posedge clk);
        #1;
        s_req_valid[1] = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("abort_raddr_before", {32'b0, m_raddr}, 64'h30);
        #2;
        rst      = 1'b1;
        m_rvalid = 1'b1;
        m_rdata  = 32'h5A5A5A5A;
        #1;
        checkOutput("abort_async_m_rd", {63'b0, m_rd}, 64'd0);
        checkOutput("abort_async_raddr", {32'b0, m_raddr}, 64'd0);
        checkOutput("abort_async_rsp_valid", {62'b0, s_rsp_valid}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("abort_no_m_rd_after", {62'b0, m_rd, m_wr}, 64'd0);
        @(posedge clk);
        #1;
        m_rvalid = 1'b0;
        m_rdata  = '0;

        s_req_we    = 2'b11;
        s_req_addr  = {32'h204, 32'h200};
        s_req_valid = 2'b11;
        waitReady(0);
        pushExpect(0, 32'h0, 1'b0, cyc_cnt + 1);
        @(posedge clk);
        #1;
        s_req_valid = 2'b10;
        waitReady(1);
        pushExpect(1, 32'h0, 1'b0, cyc_cnt + 1);
        @(posedge clk);
        #1;
        s_req_valid = '0;
        repeat (4) @(posedge clk);
        #1;

        checkOutput("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/cfg_reg_arbiter.md
# cfg_reg_arbiter

Round-robin arbiter sharing one simple register port between several requesters. The port is the register-bus side of the AXI config bridge: rd/raddr/rdata/rvalid and wr/waddr/wdata/wstrb. Typical requesters are the AXI config bridge plus local init/poll sequencers. At most one transaction is in flight downstream, with optional read timeout.

## Interface
Parameters:
- PORTS, 2, number of requesters (2..8)
- ADDR_WIDTH, 32, register address width
- DATA_WIDTH, 32, register data width
- STRB_WIDTH, DATA_WIDTH/8, write strobe width
- TIMEOUT, 255, read timeout in cycles (used only with CFG_ARB_TIMEOUT_EN; ≥1)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- s_req_valid  in  PORTS  per-requester request valid
- s_req_ready  out  PORTS  per-requester accept; one-hot or zero
- s_req_we  in  PORTS  1 = write, 0 = read
- s_req_addr  in  PORTS*ADDR_WIDTH  flattened addresses, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- s_req_wdata  in  PORTS*DATA_WIDTH  flattened write data
- s_req_wstrb  in  PORTS*STRB_WIDTH  flattened write strobes
- s_rsp_valid  out  PORTS  one-cycle completion pulse to the owner
- s_rsp_data  out  DATA_WIDTH  read data, shared; valid with s_rsp_valid
- s_rsp_err  out  1  read timed out, shared; valid with s_rsp_valid
- m_rd  out  1  downstream read strobe
- m_raddr  out  ADDR_WIDTH  downstream read address
- m_rdata  in  DATA_WIDTH  downstream read data
- m_rvalid  in  1  downstream read data valid
- m_wr  out  1  downstream write strobe
- m_waddr, m_wdata, m_wstrb  out  ADDR/DATA/STRB_WIDTH  downstream write bus

## Operation
- FSM states: IDLE, ISSUE, WAIT_RD.
- IDLE:
  - If any s_req_valid is set, the round-robin winner gets s_req_ready high for that cycle.
  - The winner's we/addr/wdata/wstrb and its index are registered; go to ISSUE.
- Round-robin: search starts at last_grant+1 and wraps modulo PORTS. last_grant updates on accept. Reset value is PORTS-1, so port 0 wins first.
- ISSUE, write:
  - m_wr=1 with the registered waddr/wdata/wstrb.
  - Owner gets s_rsp_valid=1, s_rsp_err=0, s_rsp_data=0.
  - Go to IDLE.
- ISSUE, read:
  - m_rd=1 with the registered raddr.
  - If m_rvalid=1 in this same cycle, the read completes now (see WAIT_RD).
  - Otherwise go to WAIT_RD.
- WAIT_RD: when m_rvalid=1, the owner gets s_rsp_valid=1 and s_rsp_data=m_rdata (passed combinationally), s_rsp_err=0. Go to IDLE.
- m_rvalid is ignored in IDLE and in ISSUE for a write. Stray or late data is dropped.
- m_rd and m_wr are never high together. Only one transaction is ever outstanding.
- s_rsp_data is 0 whenever s_rsp_valid is all-zero.

## Timing
- Reset values: s_req_ready=0, s_rsp_valid=0, s_rsp_data=0, s_rsp_err=0, m_rd=0, m_wr=0, all m_ addr/data/strb=0. FSM=IDLE, last_grant=PORTS-1, timeout counter=0.
- Write timeline: accepted in cycle N (valid&ready); m_wr and s_rsp_valid in N+1. The next accept is possible in N+2, giving 1 write per 2 cycles.
- Read latency: m_rd in N+1; response in the cycle m_rvalid is high, N+1 at the earliest.
- Requesters hold their request fields stable until ready. The arbiter never deasserts ready once the valid is seen in IDLE.
- Asynchronous reset mid-transaction aborts it. No response is issued, and no m_rd/m_wr occurs after reset releases.

## Configuration
- Macro CFG_ARB_TIMEOUT_EN.
- Defined: a counter clears on entry to ISSUE (read) and increments each cycle without m_rvalid.
  - When the count reaches TIMEOUT (TIMEOUT cycles after the m_rd cycle), issue s_rsp_valid with s_rsp_err=1 and s_rsp_data=0, then go to IDLE.
  - If m_rvalid arrives in that same cycle, data wins and err=0.
- Undefined: no counter, WAIT_RD waits indefinitely, s_rsp_err is tied 0, and the TIMEOUT parameter is unused.

## Structure
- Package cfg_arb_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT_RD);
  - the timeout error data constant (all-zero);
  - a width helper for the port index, $clog2(PORTS) with a minimum of 1.
- Sub-module cfg_rr_select holds the combinational round-robin pick: request vector plus last_grant in, one-hot grant plus index out. The FSM, registers and timeout stay in cfg_reg_arbiter.

## Test plan
- Single write, port 0 addr 0x10 data 0xA5A5A5A5 wstrb 0xF:
  - s_req_ready[0] in cycle N;
  - m_wr=1, m_waddr=0x10, m_wdata=0xA5A5A5A5 in N+1;
  - s_rsp_valid=2'b01, err=0 in N+1.
- Both ports request continuously from reset (PORTS=2):
  - grants alternate 0,1,0,1 on accept cycles 2 apart;
  - no m_rd and m_wr overlap.
- Read, port 1, addr 0x20, downstream returns 0x12345678 with m_rvalid 3 cycles after m_rd: s_rsp_valid=2'b10 with data 0x12345678 in that cycle. Repeat with same-cycle m_rvalid and expect the response in N+1.
- With CFG_ARB_TIMEOUT_EN and TIMEOUT=4, read with no m_rvalid:
  - s_rsp_valid with err=1, data=0 exactly 4 cycles after m_rd;
  - a stray m_rvalid one cycle later is ignored.
- Assert rst while in WAIT_RD:
  - all outputs go to 0 immediately, without waiting for a clock edge;
  - after release, port 0 wins first and no response is issued for the aborted read.
